// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the spi_pwm link: frame size, host FSM states, SPI mode.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package spi_pwm_pkg;

    localparam int FRAME_BITS = 32;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    // SPI mode 0: clock idles low, data sampled on the rising edge
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SCLK_HI,
        SCLK_LO,
        TRAIL,
        GAP
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: pulses tick on the last cycle of each CLK_DIV-cycle phase.
// Latency: tick is CLK_DIV-1 cycles after the last reload.
// Backpressure: none; reload restarts the phase immediately.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    // Count up through one phase; restart at each phase boundary or on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_pwm_host.sv
// SPI mode-0 master: shifts one 32-bit frame MSB-first per start, captures MISO.
// Latency: ss_n falls 1 cycle after start is sampled, done 66*CLK_DIV cycles later.
// Backpressure: start is ignored while busy; next frame accepted once busy drops.
module spi_pwm_host
    import spi_pwm_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  sclk,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    state_t                 state;
    logic [FRAME_BITS-1:0]  tx_sh;
    logic [FRAME_BITS-1:0]  rx_sh;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   tick;

    // Timer is held at zero while idle so the lead phase starts a full period
    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .reload (state == IDLE),
        .tick   (tick)
    );

    // Frame sequencer; every pin is registered so nothing leaks from inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sclk    <= CPOL;
            ss_n    <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= CPOL;
                    ss_n <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        tx_sh   <= tx_data;
                        mosi    <= tx_data[FRAME_BITS-1];
                        bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
                        ss_n    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        sclk  <= ~CPOL;
                        state <= SCLK_HI;
                    end
                end
                SCLK_HI: begin
                    if (tick) begin
                        rx_sh <= {rx_sh[FRAME_BITS-2:0], miso};
                        sclk  <= CPOL;
                        // Present the next bit on the falling edge; the last bit just holds
                        if (bit_cnt != '0) begin
                            mosi  <= tx_sh[FRAME_BITS-2];
                            tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                        end
                        state <= SCLK_LO;
                    end
                end
                SCLK_LO: begin
                    if (tick) begin
                        if (bit_cnt == '0) begin
                            state <= TRAIL;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                            sclk    <= ~CPOL;
                            state   <= SCLK_HI;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        ss_n    <= 1'b1;
                        rx_data <= rx_sh;
                        done    <= 1'b1;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
